// File: rtl/rx_frame_loader_if.sv
// rtl/rx_frame_loader_if.sv - UART byte stream in, image RAM write port and frame status out
interface rx_frame_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_vld;
  logic [7:0]        rx_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output rx_vld, rx_data,
    input  wr_en, wr_addr, wr_data, busy, frame_done, frame_err
  );

  modport slave (
    input  rx_vld, rx_data,
    output wr_en, wr_addr, wr_data, busy, frame_done, frame_err
  );
endinterface

// File: rtl/rx_frame_loader.sv
// rtl/rx_frame_loader.sv - parses header/pixels/checksum frames from the UART and loads the image RAM
module rx_frame_loader #(
  parameter int          IMG_W       = 28,
  parameter int          IMG_H       = 28,
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter logic [19:0] TIMEOUT_CNT = 20'd200000
) (
  input logic               clk,
  input logic               rst,
  rx_frame_loader_if.slave  bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CSUM
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [7:0]        csum;
  logic [19:0]       tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      pix_cnt        <= '0;
      csum           <= '0;
      tmo            <= '0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.wr_en      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.rx_vld && bus.rx_data == HDR_BYTE) begin
            state    <= S_DATA;
            pix_cnt  <= '0;
            csum     <= '0;
            tmo      <= '0;
            bus.busy <= 1'b1;
          end
        end
        S_DATA, S_CSUM: begin
          if (bus.rx_vld) begin
            // A byte arriving on the expiry cycle wins over the timeout.
            tmo <= '0;
            if (state == S_DATA) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= pix_cnt;
              bus.wr_data <= bus.rx_data;
              csum        <= csum + bus.rx_data;
              if (pix_cnt == LAST_PIX) begin
                state <= S_CSUM;
              end else begin
                pix_cnt <= pix_cnt + ADDR_W'(1);
              end
            end else begin
              bus.frame_done <= (bus.rx_data == csum);
              bus.frame_err  <= (bus.rx_data != csum);
              state          <= S_IDLE;
              bus.busy       <= 1'b0;
            end
          end else if (tmo == TIMEOUT_CNT - 20'd1) begin
            bus.frame_err <= 1'b1;
            state         <= S_IDLE;
            bus.busy      <= 1'b0;
          end else begin
            tmo <= tmo + 20'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rx_frame_loader.sv
// tb/tb_rx_frame_loader.sv - randomized and directed frame checks against an event-list reference model
module tb_rx_frame_loader;
  localparam int         NPIX = 8;
  localparam int         TMO  = 50;
  localparam logic [7:0] HDR  = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rx_frame_loader_if #(.ADDR_W(10)) bus ();

  rx_frame_loader #(
    .IMG_W(4), .IMG_H(2), .ADDR_W(10), .HDR_BYTE(HDR), .TIMEOUT_CNT(20'd50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // kind: 0 = pixel write, 1 = frame_done, 2 = frame_err; cyc = clock edge that produced it
  typedef struct {
    int kind;
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  bit m_in;
  int m_cnt;
  int m_sum;
  int m_last;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wr_en) obs_q.push_back('{0, cyc, int'(bus.wr_addr), int'(bus.wr_data)});
    if (bus.frame_done) obs_q.push_back('{1, cyc, 0, 0});
    if (bus.frame_err) obs_q.push_back('{2, cyc, 0, 0});
    if (bus.frame_done && bus.frame_err) check("done_err_exclusive", 1, 0);
  end

  // Frame semantics as a byte-stream interpreter: a frame is header, NPIX pixels, checksum,
  // abandoned if two consecutive in-frame bytes are more than TMO clocks apart.
  task automatic model_byte(input int b, input int e);
    if (m_in && e > m_last + TMO) begin
      exp_q.push_back('{2, m_last + TMO, 0, 0});
      m_in = 0;
    end
    if (!m_in) begin
      if (b == HDR) begin
        m_in = 1; m_cnt = 0; m_sum = 0; m_last = e;
      end
    end else begin
      m_last = e;
      if (m_cnt < NPIX) begin
        exp_q.push_back('{0, e, m_cnt, b});
        m_sum = (m_sum + b) % 256;
        m_cnt++;
      end else begin
        exp_q.push_back('{(b == m_sum) ? 1 : 2, e, 0, 0});
        m_in = 0;
      end
    end
  endtask

  task automatic model_flush(input int now);
    if (m_in && now >= m_last + TMO) begin
      exp_q.push_back('{2, m_last + TMO, 0, 0});
      m_in = 0;
    end
  endtask

  task automatic idle(input int n);
    bus.rx_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    bus.rx_vld  = 1'b1;
    bus.rx_data = b;
    model_byte(int'(b), cyc + 1);
    @(negedge clk);
    bus.rx_vld = 1'b0;
  endtask

  // Keeps rx_vld high across consecutive zero-gap bytes.
  task automatic send_frame(input logic [7:0] px [NPIX], input logic [7:0] cs, input int gap);
    if (gap == 0) begin
      bus.rx_vld = 1'b1;
      bus.rx_data = HDR;  model_byte(int'(HDR), cyc + 1); @(negedge clk);
      for (int i = 0; i < NPIX; i++) begin
        bus.rx_data = px[i]; model_byte(int'(px[i]), cyc + 1); @(negedge clk);
      end
      bus.rx_data = cs; model_byte(int'(cs), cyc + 1); @(negedge clk);
      bus.rx_vld = 1'b0;
    end else begin
      send(HDR, gap);
      for (int i = 0; i < NPIX; i++) send(px[i], gap);
      send(cs, gap);
    end
  endtask

  task automatic end_scenario(input string tag);
    idle(TMO + 5);
    model_flush(cyc);
    check({tag, "_nevents"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      check({tag, "_cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
      check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
    end
    check({tag, "_busy_after"}, int'(bus.busy), 0);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, int'(bus.wr_en), 0);
    check({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    check({tag, "_wr_data"}, int'(bus.wr_data), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.frame_done), 0);
    check({tag, "_err"}, int'(bus.frame_err), 0);
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 49;
    if (r == 1) return 50 + $urandom_range(0, 5);
    return $urandom_range(0, 2);
  endfunction

  logic [7:0] px [NPIX];
  logic [7:0] cs;
  logic [7:0] b;
  int         s;
  int         ng;
  int         r;

  initial begin
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;
    m_in = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NPIX; i++) px[i] = 8'(i + 1);
    send_frame(px, 8'h24, 1);
    end_scenario("good_frame");
    check("hold_addr", int'(bus.wr_addr), 7);
    check("hold_data", int'(bus.wr_data), 8);

    send_frame(px, 8'h25, 2);
    end_scenario("bad_csum");

    send(8'h00, 0); send(8'hFF, 1); send(8'h5A, 0);
    send_frame(px, 8'h24, 0);
    end_scenario("leading_junk");

    send(HDR, 0); send(8'h11, 0); send(8'h22, 1); send(8'h33, 0);
    idle(10);
    check("busy_midframe", int'(bus.busy), 1);
    send_frame(px, 8'h24, 45);
    end_scenario("timeout");

    px[0] = HDR;
    for (int i = 1; i < NPIX; i++) px[i] = 8'hFF;
    send_frame(px, 8'h9E, 0);
    end_scenario("wrap_hdr_data");

    for (int i = 0; i < NPIX; i++) px[i] = 8'(8'h10 + i);
    send(HDR, 0);
    for (int i = 0; i < NPIX; i++) send(px[i], (i == 3) ? 49 : 0);
    send(8'h9C, 0);
    end_scenario("gap_49_no_timeout");

    send(HDR, 0);
    for (int i = 0; i < 4; i++) send(px[i], 0);
    rst = 1'b1;
    m_in = 0;
    @(negedge clk);
    check_outputs_zero("mid_reset_a");
    @(negedge clk);
    check_outputs_zero("mid_reset_b");
    rst = 1'b0;
    for (int i = 0; i < NPIX; i++) px[i] = 8'(i + 1);
    send_frame(px, 8'h24, 0);
    end_scenario("after_reset");

    send_frame(px, 8'h24, 0);
    send_frame(px, 8'h24, 0);
    end_scenario("back_to_back");

    for (int it = 0; it < 25; it++) begin
      ng = $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == HDR) b = 8'h00;
        send(b, $urandom_range(0, 3));
      end
      s = 0;
      for (int i = 0; i < NPIX; i++) begin
        r = $urandom_range(0, 7);
        px[i] = (r == 0) ? HDR : (r == 1) ? 8'hFF : 8'($urandom_range(0, 255));
        s += int'(px[i]);
      end
      cs = 8'(s);
      if ($urandom_range(0, 3) == 0) cs = cs + 8'd1;
      send(HDR, rgap());
      for (int i = 0; i < NPIX; i++) send(px[i], rgap());
      send(cs, rgap());
      end_scenario("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
